// File: rtl/dsam_channel_scheduler_if.sv
// Request and encoder-side handshake bundle for dsam_channel_scheduler.
// master = scheduler, slave = requesters plus encoder.
interface dsam_channel_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]            req_valid;
    logic [CHANNELS*DATA_WIDTH-1:0] req_data;
    logic [CHANNELS-1:0]            req_last;
    logic [CHANNELS-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]          enc_data;
    logic                           enc_valid;
    logic [CHAN_W-1:0]              enc_chan;
    logic                           enc_first;
    logic                           enc_ready;

    modport master (
        input  req_valid, req_data, req_last, enc_ready,
        output req_ready, enc_data, enc_valid, enc_chan, enc_first
    );

    modport slave (
        output req_valid, req_data, req_last, enc_ready,
        input  req_ready, enc_data, enc_valid, enc_chan, enc_first
    );
endinterface

// File: rtl/dsam_channel_scheduler.sv
// Round-robin burst scheduler sharing one dsam_encoder between channels.
// Define DSAM_SCHED_STATS_EN to add per-channel delivered-word counters.
module dsam_channel_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef DSAM_SCHED_STATS_EN
    input  logic                    stat_clear,
    output logic [CHANNELS*32-1:0]  stat_words,
`endif
    dsam_channel_scheduler_if.master bus
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   grant_q, grant_d;
    logic [CHAN_W-1:0]   rr_q, rr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [CHAN_W-1:0]   pick;
    logic [CHAN_W-1:0]   idx;
    logic                found;
    logic                adv;
    logic                accept;
    logic [CHANNELS-1:0] rdy;
    logic [DATA_WIDTH-1:0] cur_data;

    logic [DATA_WIDTH-1:0] enc_data_q;
    logic                  enc_valid_q;
    logic [CHAN_W-1:0]     enc_chan_q;
    logic                  enc_first_q;

    assign adv      = !enc_valid_q || bus.enc_ready;
    assign accept   = (state_q == GRANT) && adv && bus.req_valid[grant_q];
    assign cur_data = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

    // Round-robin search: first valid requester after rr_q, wrapping.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = CHAN_W'((int'(rr_q) + i) % CHANNELS);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Only the granted requester sees ready, and only when output can move.
    always_comb begin
        rdy = '0;
        if (state_q == GRANT && adv)
            rdy[grant_q] = 1'b1;
    end

    assign bus.req_ready = rdy;

    // Next-state: arbitrate in IDLE, count and release bursts in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                if (adv) begin
                    if (!bus.req_valid[grant_q]) begin
                        state_d = IDLE;
                        rr_d    = grant_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        if (bus.req_last[grant_q] ||
                            cnt_d == 8'(BURST_LEN)) begin
                            state_d = IDLE;
                            rr_d    = grant_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= CHAN_W'(CHANNELS - 1);
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output stage: load on accept, drain on an empty advance, hold on stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_valid_q <= 1'b0;
            enc_data_q  <= '0;
            enc_chan_q  <= '0;
            enc_first_q <= 1'b0;
        end else if (adv) begin
            enc_valid_q <= accept;
            if (accept) begin
                enc_data_q  <= cur_data;
                enc_chan_q  <= grant_q;
                enc_first_q <= (cnt_q == 8'd0);
            end
        end
    end

    assign bus.enc_data  = enc_data_q;
    assign bus.enc_valid = enc_valid_q;
    assign bus.enc_chan  = enc_chan_q;
    assign bus.enc_first = enc_first_q;

`ifdef DSAM_SCHED_STATS_EN
    logic [31:0] stat_q [CHANNELS];

    // Count words the encoder actually takes, per source channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++)
                stat_q[i] <= 32'd0;
        end else if (stat_clear) begin
            for (int i = 0; i < CHANNELS; i++)
                stat_q[i] <= 32'd0;
        end else if (enc_valid_q && bus.enc_ready) begin
            stat_q[enc_chan_q] <= stat_q[enc_chan_q] + 32'd1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stat
        assign stat_words[g*32 +: 32] = stat_q[g];
    end
`endif
endmodule

// File: tb/tb_dsam_channel_scheduler.sv
// Directed self-checking bench for dsam_channel_scheduler.
// Covers single stream, contention, early last, stall and async reset.
module tb_dsam_channel_scheduler;
    localparam int DW = 16;
    localparam int CH = 2;
    localparam int BL = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dsam_channel_scheduler_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) bus ();

`ifdef DSAM_SCHED_STATS_EN
    logic              stat_clear;
    logic [CH*32-1:0]  stat_words;
`endif

    dsam_channel_scheduler #(
        .DATA_WIDTH(DW),
        .CHANNELS(CH),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef DSAM_SCHED_STATS_EN
        .stat_clear(stat_clear),
        .stat_words(stat_words),
`endif
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] words [CH][16];
    logic        lasts [CH][16];
    int          cnt   [CH];
    int          idx   [CH];
    logic        en    [CH];
    logic [CH-1:0] hs;
    logic [23:0] logw [$];
    int          logc [$];

    function automatic logic [23:0] mk(int c, bit f, logic [15:0] d);
        return {4'(c), 3'b000, f, d};
    endfunction

    function automatic logic [31:0] cx(bit v, bit f, int c, logic [15:0] d);
        return {12'h000, v, f, 2'(c), d};
    endfunction

    function automatic logic [31:0] cur();
        return {12'h000, bus.enc_valid, bus.enc_first,
                2'(bus.enc_chan), bus.enc_data};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(string tag, int k, logic [23:0] exp);
        check(tag, (k < logw.size()) ? 32'(logw[k]) : 32'hxxxxxxxx,
              32'(exp));
    endtask

    task automatic chk_gap(string tag, int k, int exp);
        check(tag, (k < logc.size()) ? 32'(logc[k] - logc[k-1]) : 32'hxxxxxxxx,
              32'(exp));
    endtask

    task automatic drive();
        for (int c = 0; c < CH; c++) begin
            bus.req_valid[c]         = 1'b0;
            bus.req_data[c*DW +: DW] = '0;
            bus.req_last[c]          = 1'b0;
            if (en[c] && idx[c] < cnt[c]) begin
                bus.req_valid[c]         = 1'b1;
                bus.req_data[c*DW +: DW] = words[c][idx[c]];
                bus.req_last[c]          = lasts[c][idx[c]];
            end
        end
    endtask

    task automatic load(int c, logic [15:0] base, int n, int last_at);
        for (int k = 0; k < n; k++) begin
            words[c][k] = 16'(base + 16'(k));
            lasts[c][k] = (k == last_at);
        end
        cnt[c] = n;
        idx[c] = 0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step();
        #1;
        hs = bus.req_valid & bus.req_ready;
        if (bus.enc_valid && bus.enc_ready) begin
            logw.push_back(mk(int'(bus.enc_chan), bus.enc_first,
                              bus.enc_data));
            logc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int c = 0; c < CH; c++)
            if (hs[c]) idx[c]++;
        drive();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int c = 0; c < CH; c++) begin
            en[c]  = 1'b0;
            cnt[c] = 0;
            idx[c] = 0;
        end
        bus.enc_ready = 1'b1;
`ifdef DSAM_SCHED_STATS_EN
        stat_clear = 1'b0;
`endif
        drive();
        logw.delete();
        logc.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0] t1 [9];
    logic [15:0] ed;
    int          ec;

    initial begin
        // Test 1: reset state, then a single stream of six words.
        do_reset();
        check("rst_enc", cur(), cx(0, 0, 0, 16'h0000));
        check("rst_rdy", 32'(bus.req_ready), 32'h0);
        t1[0] = cx(0, 0, 0, 16'h0000);
        t1[1] = cx(1, 1, 0, 16'h0001);
        t1[2] = cx(1, 0, 0, 16'h0002);
        t1[3] = cx(1, 0, 0, 16'h0003);
        t1[4] = cx(1, 0, 0, 16'h0004);
        t1[5] = cx(0, 0, 0, 16'h0004);
        t1[6] = cx(1, 1, 0, 16'h0005);
        t1[7] = cx(1, 0, 0, 16'h0006);
        t1[8] = cx(0, 0, 0, 16'h0006);
        load(0, 16'h0001, 6, -1);
        en[0] = 1'b1;
        drive();
        for (int s = 0; s < 9; s++) begin
            step();
            check($sformatf("single_c%0d", s + 1), cur(), t1[s]);
        end

        // Test 2: two contending streams alternate 4-word bursts.
        do_reset();
        load(0, 16'h00A0, 8, -1);
        load(1, 16'h00B0, 8, -1);
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        repeat (30) step();
        check("rr_count", 32'(logw.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            ec = (k / 4) % 2;
            ed = 16'((ec != 0 ? 16'h00B0 : 16'h00A0) + 16'((k / 8) * 4 + k % 4));
            chk_log($sformatf("rr_w%0d", k), k, mk(ec, (k % 4) == 0, ed));
        end
        for (int k = 1; k < 16; k++)
            chk_gap($sformatf("rr_gap%0d", k), k, (k % 4 == 0) ? 2 : 1);
`ifdef DSAM_SCHED_STATS_EN
        check("stat_ch0", stat_words[31:0], 32'd8);
        check("stat_ch1", stat_words[63:32], 32'd8);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("stat_clr0", stat_words[31:0], 32'd0);
        check("stat_clr1", stat_words[63:32], 32'd0);
`endif

        // Test 3: ch1 ends its burst early with req_last; ch0 follows.
        do_reset();
        load(1, 16'h0011, 2, 1);
        en[1] = 1'b1;
        drive();
        step();
        load(0, 16'h0021, 2, 1);
        en[0] = 1'b1;
        drive();
        repeat (10) step();
        check("last_count", 32'(logw.size()), 32'd4);
        chk_log("last_w0", 0, mk(1, 1, 16'h0011));
        chk_log("last_w1", 1, mk(1, 0, 16'h0012));
        chk_log("last_w2", 2, mk(0, 1, 16'h0021));
        chk_log("last_w3", 3, mk(0, 0, 16'h0022));
        chk_gap("last_gap", 2, 2);

        // Test 4: encoder stalls for three cycles while 0x0003 is held.
        do_reset();
        load(0, 16'h0001, 4, 3);
        en[0] = 1'b1;
        drive();
        repeat (4) step();
        check("bp_pre", cur(), cx(1, 0, 0, 16'h0003));
        bus.enc_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check($sformatf("bp_hold%0d", s), cur(), cx(1, 0, 0, 16'h0003));
            check($sformatf("bp_rdy%0d", s), 32'(bus.req_ready), 32'h0);
        end
        bus.enc_ready = 1'b1;
        repeat (6) step();
        check("bp_count", 32'(logw.size()), 32'd4);
        chk_log("bp_w0", 0, mk(0, 1, 16'h0001));
        chk_log("bp_w1", 1, mk(0, 0, 16'h0002));
        chk_log("bp_w2", 2, mk(0, 0, 16'h0003));
        chk_log("bp_w3", 3, mk(0, 0, 16'h0004));

        // Test 5: asynchronous reset lands in the middle of a burst.
        do_reset();
        load(0, 16'h0001, 6, -1);
        load(1, 16'h0031, 2, -1);
        en[0] = 1'b1;
        en[1] = 1'b1;
        drive();
        repeat (3) step();
        check("ar_pre", cur(), cx(1, 0, 0, 16'h0002));
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(bus.enc_valid), 32'h0);
        check("ar_rdy", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        logw.delete();
        logc.delete();
        reset = 1'b1;
        repeat (8) step();
        chk_log("ar_w0", 0, mk(0, 1, 16'h0003));
        chk_log("ar_w1", 1, mk(0, 0, 16'h0004));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
